ex_stall_ctrl: RTL

//  Pipeline sequencing controller for the ID/EX stage. Drives the enable and bubble controls of PC, IF/ID and ID/EX.

---
 rtl/ex_stall_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ex_stall_ctrl.sv
// ex_stall_ctrl: ID/EX pipeline sequencing controller.
// It drives the PC, IF/ID and ID/EX enables and the ID/EX bubble. While the
// iterative MULTU unit runs it steps the unit and holds the pipeline frozen.
// It inserts one bubble for each load-use hazard and honours a memory-wait
// freeze. Optional feature: define STALL_CNT_EN to build the saturating
// frozen-cycle counter on stall_cycles. When it is not defined, stall_cycles
// is tied to zero.
module ex_stall_ctrl #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_multu,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        mem_stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        mul_start,
  output logic        mul_step,
  output logic        hilo_we,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hazard;

  // A load into $zero never creates a real dependency.
  assign hazard = ex_memread && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt));

  // State and step counter. Both are frozen while memory is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!mem_stall) begin
      case (state)
        IDLE: begin
          if (ex_multu) begin
            state <= MUL;
            cnt   <= CNT_INIT;
          end
        end
        MUL: begin
          if (cnt == '0) state <= WB;
          else           cnt   <= cnt - 1'b1;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Control decode. Reset forces the idle values, and then mem_stall
  // freezes everything. In IDLE a MULTU takes priority over a load-use
  // hazard.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    mul_start   = 1'b0;
    mul_step    = 1'b0;
    hilo_we     = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      if (mem_stall) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ex_multu) begin
              mul_start = 1'b1;
              pc_en     = 1'b0;
              if_id_en  = 1'b0;
              id_ex_en  = 1'b0;
            end else if (hazard) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end
          end
          MUL: begin
            mul_step = 1'b1;
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
          end
          WB:      hilo_we = 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Count the cycles in which the PC is held, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= 32'd0;
    else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
